// File: rtl/inst_seq_ctrl.sv
// Execute-stage sequencer for the 12-bit baseline PIC core: decode, PC control, SLEEP/wake, flush.
// Optional stack depth checking is built when INST_SEQ_STACK_CHECK_EN is defined.
module inst_seq_ctrl #(
  parameter int STACK_DEPTH = 2,
  parameter int WAKE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        alu_zero,
  input  logic        bit_val,
  input  logic        wake,
  output logic        ir_skip,
  output logic        imm_oe,
  output logic        pc_load,
  output logic        pc_push,
  output logic        pc_pop,
  output logic        pc_hold,
  output logic        sleeping,
  output logic        stk_ovf,
  output logic        stk_unf
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_SLEEP, S_WAKE} state_e;

  state_e     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;

  logic is_goto, is_call, is_retlw, is_lit, is_fsz, is_btfsc, is_btfss, is_sleep;

  assign is_goto  = (inst[11:9] == 3'b101);
  assign is_call  = (inst[11:8] == 4'b1001);
  assign is_retlw = (inst[11:8] == 4'b1000);
  assign is_lit   = (inst[11:10] == 2'b11);
  assign is_fsz   = (inst[11:6] == 6'b001011) || (inst[11:6] == 6'b001111);
  assign is_btfsc = (inst[11:8] == 4'b0110);
  assign is_btfss = (inst[11:8] == 4'b0111);
  assign is_sleep = (inst == 12'h003);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_BOOT;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ir_skip  = 1'b0;
    imm_oe   = 1'b0;
    pc_load  = 1'b0;
    pc_push  = 1'b0;
    pc_pop   = 1'b0;
    pc_hold  = 1'b0;
    sleeping = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        ir_skip = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (is_goto) begin
          pc_load = 1'b1;
          imm_oe  = 1'b1;
          ir_skip = 1'b1;
        end else if (is_call) begin
          pc_load = 1'b1;
          pc_push = 1'b1;
          imm_oe  = 1'b1;
          ir_skip = 1'b1;
        end else if (is_retlw) begin
          pc_pop  = 1'b1;
          imm_oe  = 1'b1;
          ir_skip = 1'b1;
        end else if (is_lit) begin
          imm_oe  = 1'b1;
        end else if (is_fsz) begin
          ir_skip = alu_zero;
        end else if (is_btfsc) begin
          ir_skip = ~bit_val;
        end else if (is_btfss) begin
          ir_skip = bit_val;
        end else if (is_sleep) begin
          // wake in the same cycle is deliberately not looked at here
          pc_hold = 1'b1;
          ir_skip = 1'b1;
          state_d = S_SLEEP;
        end
      end
      S_SLEEP: begin
        sleeping = 1'b1;
        pc_hold  = 1'b1;
        ir_skip  = 1'b1;
        if (wake) begin
          state_d = S_WAKE;
          wcnt_d  = 3'(WAKE_CYCLES);
        end
      end
      S_WAKE: begin
        ir_skip = 1'b1;
        wcnt_d  = wcnt_q - 3'd1;
        if (wcnt_q <= 3'd1) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

`ifdef INST_SEQ_STACK_CHECK_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, unf_q;
  logic          ovf_set, unf_set;

  // Flags show in the offending cycle and then hold until reset.
  assign ovf_set = pc_push && (depth_q == DW'(STACK_DEPTH));
  assign unf_set = pc_pop && (depth_q == '0);
  assign stk_ovf = ovf_q | ovf_set;
  assign stk_unf = unf_q | unf_set;

  always_comb begin
    depth_d = depth_q;
    if (pc_push && !ovf_set) depth_d = depth_q + DW'(1);
    else if (pc_pop && !unf_set) depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= stk_ovf;
      unf_q   <= stk_unf;
    end
  end
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed bench for inst_seq_ctrl: reset, decode, skips, SLEEP/wake, stack flags.
module tb_inst_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] inst = 12'h000;
  logic        alu_zero = 1'b0;
  logic        bit_val = 1'b0;
  logic        wake = 1'b0;
  logic        ir_skip, imm_oe, pc_load, pc_push, pc_pop, pc_hold, sleeping, stk_ovf, stk_unf;

  int errors = 0;
  int checks = 0;

`ifdef INST_SEQ_STACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  inst_seq_ctrl #(.STACK_DEPTH(2), .WAKE_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .inst(inst), .alu_zero(alu_zero), .bit_val(bit_val),
    .wake(wake), .ir_skip(ir_skip), .imm_oe(imm_oe), .pc_load(pc_load), .pc_push(pc_push),
    .pc_pop(pc_pop), .pc_hold(pc_hold), .sleeping(sleeping), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clock = ~clock;

  // Applies inputs just after a falling edge; outputs are then sampled mid-low-phase.
  task automatic drive(input logic [11:0] i, input logic az, input logic bv, input logic wk);
    @(negedge clock);
    inst = i; alu_zero = az; bit_val = bv; wake = wk;
    #1;
  endtask

  // Holds reset for two rising edges; returns with the DUT in BOOT.
  task automatic do_reset(input logic [11:0] i, input logic wk);
    @(negedge clock);
    reset = 1'b1; inst = i; wake = wk;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset(12'hC55, 1'b0);
    checks++; if (ir_skip !== 1'b1) begin errors++; $display("FAIL boot_ir_skip got=%b exp=1", ir_skip); end
    checks++; if ({imm_oe, pc_load, pc_push, pc_pop, pc_hold, sleeping, stk_ovf, stk_unf} !== 8'h00) begin
      errors++; $display("FAIL boot_ctrl got=%b%b%b%b%b%b%b%b exp=00000000", imm_oe, pc_load, pc_push, pc_pop, pc_hold, sleeping, stk_ovf, stk_unf);
    end
    drive(12'hC55, 1'b0, 1'b0, 1'b0);
    checks++; if ({imm_oe, ir_skip, pc_load} !== 3'b100) begin
      errors++; $display("FAIL movlw got imm_oe=%b ir_skip=%b pc_load=%b exp=1 0 0", imm_oe, ir_skip, pc_load);
    end
  endtask

  task automatic test_goto;
    drive(12'hA2F, 1'b0, 1'b0, 1'b0);
    checks++; if ({pc_load, imm_oe, ir_skip, pc_push, pc_pop, pc_hold} !== 6'b111000) begin
      errors++; $display("FAIL goto got=%b%b%b%b%b%b exp=111000", pc_load, imm_oe, ir_skip, pc_push, pc_pop, pc_hold);
    end
    drive(12'h000, 1'b1, 1'b1, 1'b0);
    checks++; if ({pc_load, imm_oe, ir_skip, pc_push, pc_pop, pc_hold, sleeping} !== 7'b0) begin
      errors++; $display("FAIL nop got=%b%b%b%b%b%b%b exp=0000000", pc_load, imm_oe, ir_skip, pc_push, pc_pop, pc_hold, sleeping);
    end
  endtask

  task automatic test_call_retlw;
    drive(12'h910, 1'b0, 1'b0, 1'b0);
    checks++; if ({pc_load, pc_push, imm_oe, ir_skip, pc_pop} !== 5'b11110) begin
      errors++; $display("FAIL call got=%b%b%b%b%b exp=11110", pc_load, pc_push, imm_oe, ir_skip, pc_pop);
    end
    drive(12'h800, 1'b0, 1'b0, 1'b0);
    checks++; if ({pc_pop, imm_oe, ir_skip, pc_load, pc_push} !== 5'b11100) begin
      errors++; $display("FAIL retlw got=%b%b%b%b%b exp=11100", pc_pop, imm_oe, ir_skip, pc_load, pc_push);
    end
  endtask

  task automatic test_skips;
    drive(12'h2E5, 1'b1, 1'b0, 1'b0);
    checks++; if (ir_skip !== 1'b1) begin errors++; $display("FAIL decfsz_z got=%b exp=1", ir_skip); end
    drive(12'h2E5, 1'b0, 1'b0, 1'b0);
    checks++; if (ir_skip !== 1'b0) begin errors++; $display("FAIL decfsz_nz got=%b exp=0", ir_skip); end
    drive(12'h3C1, 1'b1, 1'b0, 1'b0);
    checks++; if (ir_skip !== 1'b1) begin errors++; $display("FAIL incfsz_z got=%b exp=1", ir_skip); end
    drive(12'h2A5, 1'b1, 1'b1, 1'b0);
    checks++; if (ir_skip !== 1'b0) begin errors++; $display("FAIL decf_noskip got=%b exp=0", ir_skip); end
    drive(12'h7A3, 1'b0, 1'b1, 1'b0);
    checks++; if (ir_skip !== 1'b1) begin errors++; $display("FAIL btfss_1 got=%b exp=1", ir_skip); end
    drive(12'h7A3, 1'b0, 1'b0, 1'b0);
    checks++; if (ir_skip !== 1'b0) begin errors++; $display("FAIL btfss_0 got=%b exp=0", ir_skip); end
    drive(12'h6A3, 1'b0, 1'b0, 1'b0);
    checks++; if (ir_skip !== 1'b1) begin errors++; $display("FAIL btfsc_0 got=%b exp=1", ir_skip); end
    drive(12'h6A3, 1'b0, 1'b1, 1'b0);
    checks++; if (ir_skip !== 1'b0) begin errors++; $display("FAIL btfsc_1 got=%b exp=0", ir_skip); end
    drive(12'h004, 1'b1, 1'b1, 1'b0);
    checks++; if ({ir_skip, imm_oe, pc_hold} !== 3'b000) begin
      errors++; $display("FAIL clrwdt got=%b%b%b exp=000", ir_skip, imm_oe, pc_hold);
    end
  endtask

  task automatic test_sleep_wake;
    drive(12'h003, 1'b0, 1'b0, 1'b1);
    checks++; if ({pc_hold, ir_skip, sleeping} !== 3'b110) begin
      errors++; $display("FAIL sleep_decode got=%b%b%b exp=110", pc_hold, ir_skip, sleeping);
    end
    for (int k = 0; k < 5; k++) begin
      drive(12'hA2F, 1'b0, 1'b0, 1'b0);
      checks++; if ({sleeping, pc_hold, ir_skip, pc_load, imm_oe} !== 5'b11100) begin
        errors++; $display("FAIL sleep_hold[%0d] got=%b%b%b%b%b exp=11100", k, sleeping, pc_hold, ir_skip, pc_load, imm_oe);
      end
    end
    drive(12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (sleeping !== 1'b1) begin errors++; $display("FAIL wake_cycle got=%b exp=1", sleeping); end
    drive(12'hC12, 1'b0, 1'b0, 1'b0);
    checks++; if ({sleeping, ir_skip, pc_hold, imm_oe} !== 4'b0100) begin
      errors++; $display("FAIL wake_flush got=%b%b%b%b exp=0100", sleeping, ir_skip, pc_hold, imm_oe);
    end
    drive(12'hC12, 1'b0, 1'b0, 1'b0);
    checks++; if ({sleeping, ir_skip, imm_oe} !== 3'b001) begin
      errors++; $display("FAIL wake_run got=%b%b%b exp=001", sleeping, ir_skip, imm_oe);
    end
    drive(12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if ({sleeping, ir_skip} !== 2'b00) begin
      errors++; $display("FAIL wake_in_run got=%b%b exp=00", sleeping, ir_skip);
    end
  endtask

  task automatic test_back_to_back;
    drive(12'hA10, 1'b0, 1'b0, 1'b0);
    drive(12'hB20, 1'b0, 1'b0, 1'b0);
    checks++; if ({pc_load, ir_skip} !== 2'b11) begin
      errors++; $display("FAIL b2b_goto got=%b%b exp=11", pc_load, ir_skip);
    end
  endtask

  task automatic test_stack;
    do_reset(12'h000, 1'b0);
    drive(12'h910, 1'b0, 1'b0, 1'b0);
    checks++; if (stk_ovf !== 1'b0) begin errors++; $display("FAIL ovf_call1 got=%b exp=0", stk_ovf); end
    drive(12'h910, 1'b0, 1'b0, 1'b0);
    checks++; if (stk_ovf !== 1'b0) begin errors++; $display("FAIL ovf_call2 got=%b exp=0", stk_ovf); end
    drive(12'h910, 1'b0, 1'b0, 1'b0);
    checks++; if (stk_ovf !== CHK) begin errors++; $display("FAIL ovf_call3 got=%b exp=%b", stk_ovf, CHK); end
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    checks++; if ({stk_ovf, stk_unf} !== {CHK, 1'b0}) begin
      errors++; $display("FAIL ovf_sticky got=%b%b exp=%b0", stk_ovf, stk_unf, CHK);
    end
    do_reset(12'h000, 1'b0);
    checks++; if ({stk_ovf, stk_unf} !== 2'b00) begin
      errors++; $display("FAIL flags_after_reset got=%b%b exp=00", stk_ovf, stk_unf);
    end
    drive(12'h800, 1'b0, 1'b0, 1'b0);
    checks++; if (stk_unf !== CHK) begin errors++; $display("FAIL unf_retlw got=%b exp=%b", stk_unf, CHK); end
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    checks++; if ({stk_unf, stk_ovf} !== {CHK, 1'b0}) begin
      errors++; $display("FAIL unf_sticky got=%b%b exp=%b0", stk_unf, stk_ovf, CHK);
    end
  endtask

  task automatic test_reset_in_sleep;
    do_reset(12'h000, 1'b0);
    repeat (3) drive(12'h910, 1'b0, 1'b0, 1'b0);
    drive(12'h003, 1'b0, 1'b0, 1'b0);
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    checks++; if (sleeping !== 1'b1) begin errors++; $display("FAIL pre_reset_sleep got=%b exp=1", sleeping); end
    do_reset(12'h000, 1'b1);
    wake = 1'b0;
    #1;
    checks++; if ({sleeping, ir_skip, pc_hold, stk_ovf, stk_unf} !== 5'b01000) begin
      errors++; $display("FAIL reset_in_sleep got=%b%b%b%b%b exp=01000", sleeping, ir_skip, pc_hold, stk_ovf, stk_unf);
    end
    drive(12'hC01, 1'b0, 1'b0, 1'b0);
    checks++; if ({imm_oe, ir_skip, sleeping} !== 3'b100) begin
      errors++; $display("FAIL run_after_reset got=%b%b%b exp=100", imm_oe, ir_skip, sleeping);
    end
  endtask

  initial begin
    test_reset;
    test_goto;
    test_call_retlw;
    test_skips;
    test_sleep_wake;
    test_back_to_back;
    test_stack;
    test_reset_in_sleep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
